// File: rtl/mc_datapath_regs.sv
// Multi-cycle MIPS datapath registers: PC, IR, MDR, A, B, ALUOut and the
// combinational address, operand, write-back and next-PC selects around them.
module mc_datapath_regs #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_PCWrite,
    input  logic        i_PCWriteCond,
    input  logic        i_IRWrite,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic        i_RegWrite,
    input  logic [1:0]  i_IorD,
    input  logic [1:0]  i_PCSource,
    input  logic [1:0]  i_ALUSrcA,
    input  logic [1:0]  i_ALUSrcB,
    input  logic [1:0]  i_RegDst,
    input  logic [1:0]  i_MemtoReg,
    input  logic [31:0] i_alu_result,
    input  logic        i_zero,
    input  logic [31:0] i_mem_rdata,
    input  logic [31:0] i_rf_rdata1,
    input  logic [31:0] i_rf_rdata2,
    output logic [5:0]  o_op,
    output logic [5:0]  o_funct,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [4:0]  o_rf_waddr,
    output logic [31:0] o_rf_wdata,
    output logic        o_rf_we,
    output logic [31:0] o_pc
);

    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_out;
    logic [31:0] next_pc;
    logic [31:0] imm_s;
    logic [31:0] shamt;
    logic        pc_en;

    assign imm_s = {{16{ir[15]}}, ir[15:0]};
    assign shamt = {27'd0, ir[10:6]};
    assign pc_en = i_PCWrite | (i_PCWriteCond & i_zero);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc      <= PC_RESET;
            ir      <= '0;
            mdr     <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
        end else begin
            if (pc_en)
                pc <= next_pc;
            if (i_IRWrite)
                ir <= i_mem_rdata;
            mdr     <= i_mem_rdata;
            a       <= i_rf_rdata1;
            b       <= i_rf_rdata2;
            alu_out <= i_alu_result;
        end
    end

    always_comb begin
        o_mem_addr = pc;
        unique case (i_IorD)
            2'b00: o_mem_addr = pc;
            2'b01: o_mem_addr = alu_out;
            2'b10: o_mem_addr = a;
            2'b11: o_mem_addr = pc;
        endcase
    end

    always_comb begin
        o_alu_a = pc;
        unique case (i_ALUSrcA)
            2'b00: o_alu_a = pc;
            2'b01: o_alu_a = a;
            2'b10: o_alu_a = shamt;
            2'b11: o_alu_a = 32'h0;
        endcase
    end

    always_comb begin
        o_alu_b = b;
        unique case (i_ALUSrcB)
            2'b00: o_alu_b = b;
            2'b01: o_alu_b = 32'd4;
            2'b10: o_alu_b = imm_s;
            2'b11: o_alu_b = {imm_s[29:0], 2'b00};
        endcase
    end

    // Jump target takes the upper nibble of the already-incremented PC.
    always_comb begin
        next_pc = i_alu_result;
        unique case (i_PCSource)
            2'b00: next_pc = i_alu_result;
            2'b01: next_pc = alu_out;
            2'b10: next_pc = {pc[31:28], ir[25:0], 2'b00};
            2'b11: next_pc = a;
        endcase
    end

    always_comb begin
        o_rf_waddr = ir[20:16];
        unique case (i_RegDst)
            2'b00: o_rf_waddr = ir[20:16];
            2'b01: o_rf_waddr = ir[15:11];
            2'b10: o_rf_waddr = 5'd31;
            2'b11: o_rf_waddr = ir[20:16];
        endcase
    end

    always_comb begin
        o_rf_wdata = alu_out;
        unique case (i_MemtoReg)
            2'b00: o_rf_wdata = alu_out;
            2'b01: o_rf_wdata = mdr;
            2'b10: o_rf_wdata = pc;
            2'b11: o_rf_wdata = {ir[15:0], 16'h0};
        endcase
    end

    assign o_op        = ir[31:26];
    assign o_funct     = ir[5:0];
    assign o_rs        = ir[25:21];
    assign o_rt        = ir[20:16];
    assign o_mem_wdata = b;
    assign o_mem_rd    = i_MemRead;
    assign o_mem_wr    = i_MemWrite;
    assign o_rf_we     = i_RegWrite;
    assign o_pc        = pc;

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Directed and randomized bench for mc_datapath_regs against an
// architectural model of its six registers.
module tb_mc_datapath_regs;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write;
    logic [1:0]  iord, pc_source, alu_src_a, alu_src_b, reg_dst, mem_to_reg;
    logic [31:0] alu_result, mem_rdata, rf_rdata1, rf_rdata2;
    logic        zero;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rf_waddr;
    logic [31:0] mem_addr, mem_wdata, alu_a, alu_b, rf_wdata, pc;
    logic        mem_rd, mem_wr, rf_we;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;

    always #5 clk = ~clk;

    mc_datapath_regs #(.PC_RESET(RST_PC)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_PCWrite(pc_write), .i_PCWriteCond(pc_write_cond),
        .i_IRWrite(ir_write), .i_MemRead(mem_read),
        .i_MemWrite(mem_write), .i_RegWrite(reg_write),
        .i_IorD(iord), .i_PCSource(pc_source),
        .i_ALUSrcA(alu_src_a), .i_ALUSrcB(alu_src_b),
        .i_RegDst(reg_dst), .i_MemtoReg(mem_to_reg),
        .i_alu_result(alu_result), .i_zero(zero),
        .i_mem_rdata(mem_rdata),
        .i_rf_rdata1(rf_rdata1), .i_rf_rdata2(rf_rdata2),
        .o_op(op), .o_funct(funct), .o_rs(rs), .o_rt(rt),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_mem_rd(mem_rd), .o_mem_wr(mem_wr),
        .o_alu_a(alu_a), .o_alu_b(alu_b),
        .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
        .o_rf_we(rf_we), .o_pc(pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC;
        m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] imm, sh, jt;
        logic [31:0] addr_o[4], a_o[4], b_o[4], wd_o[4], wa_o[4];
        imm = 32'($signed(m_ir[15:0]));
        sh  = (m_ir >> 6) % 32;
        addr_o = '{m_pc, m_aluout, m_a, m_pc};
        a_o    = '{m_pc, m_a, sh, 32'd0};
        b_o    = '{m_b, 32'd4, imm, imm * 4};
        wa_o   = '{(m_ir >> 16) % 32, (m_ir >> 11) % 32, 32'd31, (m_ir >> 16) % 32};
        wd_o   = '{m_aluout, m_mdr, m_pc, m_ir * 65536};
        chk({tag, ".op"}, 32'(op), m_ir / (2 ** 26));
        chk({tag, ".funct"}, 32'(funct), m_ir % 64);
        chk({tag, ".rs"}, 32'(rs), (m_ir >> 21) % 32);
        chk({tag, ".rt"}, 32'(rt), (m_ir >> 16) % 32);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".mem_addr"}, mem_addr, addr_o[iord]);
        chk({tag, ".mem_wdata"}, mem_wdata, m_b);
        chk({tag, ".alu_a"}, alu_a, a_o[alu_src_a]);
        chk({tag, ".alu_b"}, alu_b, b_o[alu_src_b]);
        chk({tag, ".rf_waddr"}, 32'(rf_waddr), wa_o[reg_dst]);
        chk({tag, ".rf_wdata"}, rf_wdata, wd_o[mem_to_reg]);
        chk({tag, ".strobes"}, {29'd0, mem_rd, mem_wr, rf_we},
            {29'd0, mem_read, mem_write, reg_write});
        jt = 0;
    endtask

    // One rising edge; the model commits what the registers should capture.
    task automatic step();
        logic [31:0] pc_o[4], n_pc, n_ir;
        pc_o = '{alu_result, m_aluout,
                 (m_pc & 32'hF000_0000) + (m_ir & 32'h03FF_FFFF) * 4, m_a};
        n_pc = (pc_write || (pc_write_cond && zero)) ? pc_o[pc_source] : m_pc;
        n_ir = ir_write ? mem_rdata : m_ir;
        @(posedge clk);
        if (rst_n) begin
            m_pc = n_pc; m_ir = n_ir; m_mdr = mem_rdata;
            m_a = rf_rdata1; m_b = rf_rdata2; m_aluout = alu_result;
        end
        #1;
    endtask

    task automatic idle();
        {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write} = '0;
        {iord, pc_source, alu_src_a, alu_src_b, reg_dst, mem_to_reg} = '0;
        zero = 0;
    endtask

    initial begin
        rst_n = 0;
        idle();
        alu_result = 0; mem_rdata = 0; rf_rdata1 = 0; rf_rdata2 = 0;
        model_reset();
        step(); step();
        check_all("por");
        rst_n = 1;

        // Asynchronous reset in the middle of an instruction
        pc_write = 1; ir_write = 1; alu_result = 32'h1234; mem_rdata = 32'hFFFF_FFFF;
        step();
        chk("pre_rst.pc", pc, 32'h1234);
        #2 rst_n = 0; #1;
        model_reset();
        chk("rst.pc", pc, RST_PC);
        chk("rst.op", 32'(op), 0);
        check_all("rst");
        step(); step();
        chk("rst_hold.pc", pc, RST_PC);
        chk("rst_hold.op", 32'(op), 0);
        check_all("rst_hold");
        rst_n = 1;

        // Fetch from PC=0
        idle(); pc_write = 1; alu_result = 0; mem_rdata = 0;
        step();
        ir_write = 1; pc_write = 1; alu_src_b = 2'b01;
        mem_rdata = 32'h8C22_0004; alu_result = 4;
        #1;
        chk("fetch.addr", mem_addr, 0);
        chk("fetch.alu_b", alu_b, 4);
        step();
        chk("fetch.pc", pc, 4);
        chk("fetch.op", 32'(op), 32'h23);
        chk("fetch.rs", 32'(rs), 1);
        chk("fetch.rt", 32'(rt), 2);
        idle(); alu_src_b = 2'b10; #1;
        chk("fetch.imm", alu_b, 4);
        check_all("fetch");

        // Branch
        idle(); ir_write = 1; pc_write = 1; mem_rdata = 32'h1000_FFFF; alu_result = 8;
        step();
        idle(); alu_src_b = 2'b11; alu_result = 4; rf_rdata1 = 8; #1;
        chk("br.alu_b", alu_b, 32'hFFFF_FFFC);
        step();
        idle(); pc_write_cond = 1; pc_source = 2'b01; zero = 1;
        step();
        chk("br.taken", pc, 4);
        idle(); pc_write = 1; pc_source = 2'b11; alu_result = 4;
        step();
        chk("br.restore", pc, 8);
        idle(); pc_write_cond = 1; pc_source = 2'b01; zero = 0;
        step();
        chk("br.not_taken", pc, 8);
        idle(); pc_write = 1; pc_write_cond = 1; pc_source = 2'b01; zero = 0;
        step();
        chk("br.uncond", pc, 4);

        // Jump and link
        idle(); ir_write = 1; pc_write = 1;
        mem_rdata = 32'h0C00_0040; alu_result = 32'h9000_0010;
        step();
        idle(); reg_dst = 2'b10; mem_to_reg = 2'b10; reg_write = 1; #1;
        chk("jal.waddr", 32'(rf_waddr), 31);
        chk("jal.wdata", rf_wdata, 32'h9000_0010);
        check_all("jal.link");
        idle(); pc_source = 2'b10; pc_write = 1;
        step();
        chk("jal.pc", pc, 32'h9000_0100);

        // Load/store path
        idle(); alu_result = 32'h100;
        step();
        iord = 2'b01; mem_read = 1; mem_rdata = 32'hDEAD_BEEF;
        rf_rdata1 = 32'h200; rf_rdata2 = 32'h55; #1;
        chk("ld.addr", mem_addr, 32'h100);
        step();
        idle(); mem_to_reg = 2'b01; #1;
        chk("ld.wdata", rf_wdata, 32'hDEAD_BEEF);
        iord = 2'b10; mem_write = 1; #1;
        chk("st.addr", mem_addr, 32'h200);
        chk("st.wdata", mem_wdata, 32'h55);
        check_all("st");

        // LUI and shift
        idle(); ir_write = 1; mem_rdata = 32'h3C01_1234;
        step();
        idle(); mem_to_reg = 2'b11; #1;
        chk("lui.wdata", rf_wdata, 32'h1234_0000);
        idle(); ir_write = 1; mem_rdata = 32'h0002_1140;
        step();
        idle(); alu_src_a = 2'b10; reg_dst = 2'b01; #1;
        chk("sll.alu_a", alu_a, 5);
        check_all("sll");

        // Randomized controls and data against the model
        for (int i = 0; i < 400; i++) begin
            {pc_write, pc_write_cond, ir_write} = 3'($urandom);
            {mem_read, mem_write, reg_write, zero} = 4'($urandom);
            {iord, pc_source, alu_src_a, alu_src_b, reg_dst, mem_to_reg} = 12'($urandom);
            alu_result = $urandom; mem_rdata = $urandom;
            rf_rdata1 = $urandom; rf_rdata2 = $urandom;
            #1;
            check_all("rnd");
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 0; #1;
                model_reset();
                check_all("rnd_rst");
                rst_n = 1;
            end
            step();
        end
        check_all("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_datapath_regs.md
# mc_datapath_regs

Multi-cycle MIPS datapath register stage that sits directly downstream of the top-level control FSM. It consumes every control strobe and select the FSM produces, and holds the architectural and inter-cycle registers: PC, IR, MDR, A, B and ALUOut. It forms the memory address, the ALU operands, the register-file write address/data and the next PC. It returns op/funct to the FSM and accepts result/zero from the external ALU.

## Interface
- PC_RESET, 32'h0000_0000, PC value loaded on reset
- i_clk  in  1  rising-edge clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_PCWrite, i_PCWriteCond, i_IRWrite, i_MemRead, i_MemWrite, i_RegWrite  in  1 each  FSM strobes
- i_IorD, i_PCSource, i_ALUSrcA, i_ALUSrcB, i_RegDst, i_MemtoReg  in  2 each  FSM selects
- i_alu_result  in  32  combinational ALU output
- i_zero  in  1  ALU zero flag
- i_mem_rdata  in  32  memory read data, combinational, valid in the same cycle as o_mem_addr
- i_rf_rdata1, i_rf_rdata2  in  32  register-file read ports, driven by o_rs and o_rt
- o_op, o_funct  out  6 each  IR[31:26], IR[5:0]
- o_rs, o_rt  out  5 each  IR[25:21], IR[20:16]
- o_mem_addr  out  32  memory address
- o_mem_wdata  out  32  equals B
- o_mem_rd, o_mem_wr  out  1 each  pass-through of i_MemRead, i_MemWrite
- o_alu_a, o_alu_b  out  32 each  ALU operands
- o_rf_waddr  out  5  register-file write address
- o_rf_wdata  out  32  register-file write data
- o_rf_we  out  1  pass-through of i_RegWrite
- o_pc  out  32  current PC

## Operation
- Registers: PC, IR, MDR, A, B, ALUOut, each 32 bits.
  - MDR, A, B and ALUOut load every cycle from i_mem_rdata, i_rf_rdata1, i_rf_rdata2 and i_alu_result respectively.
  - IR loads i_mem_rdata only when i_IRWrite=1. It loads whether or not i_MemRead is asserted.
  - PC loads next_pc when pc_en = i_PCWrite | (i_PCWriteCond & i_zero).
- imm_s = sign-extended IR[15:0]. shamt = zero-extended IR[10:6].
- i_IorD selects o_mem_addr:
  - 00: PC
  - 01: ALUOut
  - 10: A
  - 11: PC
- i_ALUSrcA selects o_alu_a:
  - 00: PC
  - 01: A
  - 10: shamt
  - 11: 32'h0
- i_ALUSrcB selects o_alu_b:
  - 00: B
  - 01: 32'd4
  - 10: imm_s
  - 11: imm_s<<2
- i_PCSource selects next_pc:
  - 00: i_alu_result
  - 01: ALUOut
  - 10: {PC[31:28], IR[25:0], 2'b00}
  - 11: A
- i_RegDst selects o_rf_waddr:
  - 00: IR[20:16]
  - 01: IR[15:11]
  - 10: 5'd31
  - 11: IR[20:16]
- i_MemtoReg selects o_rf_wdata:
  - 00: ALUOut
  - 01: MDR
  - 10: PC (link value)
  - 11: {IR[15:0], 16'h0}
- Jump target (PCSource=10) uses the current PC register. The FSM has already incremented PC during fetch.
- No alignment checks. PC and addresses are stored and driven unmodified.
- All arithmetic wraps modulo 2^32. imm_s<<2 discards bits shifted out of 32.

## Timing
- Reset values, applied asynchronously on i_rst_n=0 and held while low:
  - PC = PC_RESET; IR, MDR, A, B, ALUOut = 0.
  - Hence o_op=0, o_funct=0, o_rs=0, o_rt=0, o_pc=PC_RESET, o_mem_wdata=0.
  - o_mem_addr, o_alu_a/b, o_rf_waddr/wdata follow their selects over the reset register values.
  - o_mem_rd, o_mem_wr and o_rf_we follow their inputs; during reset the FSM drives these low.
- Reset release: first load occurs on the first rising edge with i_rst_n=1.
- All mux outputs are combinational from register values and current selects, with zero latency.
- Every register updates on the same rising edge. Values written at edge N are visible on outputs after edge N.
- Fetch (IRWrite=1, PCWrite=1, PCSource=00, IorD=00, ALUSrcA=00, ALUSrcB=01) completes in one edge:
  - IR receives mem[PC].
  - PC receives PC+4.
  - o_mem_addr uses the pre-edge PC.
- i_PCWrite=1 together with i_PCWriteCond=1: PC loads regardless of i_zero.
- i_PCWriteCond=1 with i_zero=0: PC holds.
- Select values change only take effect through combinational paths. There is no pipelining of controls.
- Reset asserted mid-instruction: all registers clear immediately, without waiting for a clock edge. A partially completed instruction is discarded.

## Test plan
- Reset:
  - Stimulus: assert i_rst_n=0 between clock edges with PC_RESET=32'h0040_0000.
  - Required: o_pc=0x00400000 and o_op=0 immediately, with no clock edge. Registers stay cleared across two edges while reset is held.
- Fetch:
  - Stimulus: PC=0, i_mem_rdata=0x8C220004, fetch controls as in Timing, i_alu_result=4.
  - Required after one edge: o_pc=4, o_op=6'h23, o_rs=1, o_rt=2.
  - Required next cycle with ALUSrcB=10: o_alu_b=4.
- Branch:
  - Stimulus: IR=0x1000FFFF, PC=8, ALUSrcB=11.
  - Required: o_alu_b=0xFFFFFFFC.
  - Stimulus: PCWriteCond=1, PCSource=01, ALUOut=4, i_zero=1.
  - Required: PC=4.
  - Stimulus: same with i_zero=0.
  - Required: PC stays 8.
- Jump and link:
  - Stimulus: PC=0x90000010, IR=0x0C000040, PCSource=10, PCWrite=1.
  - Required: PC=0x90000100.
  - Stimulus (prior cycle): RegDst=10, MemtoReg=10.
  - Required: o_rf_waddr=31, o_rf_wdata=0x90000010.
- Load/store path:
  - Stimulus: ALUOut=0x100, IorD=01, MemRead=1, i_mem_rdata=0xDEADBEEF.
  - Required after one edge, with MemtoReg=01: o_rf_wdata=0xDEADBEEF.
  - Stimulus: IorD=10, A=0x200.
  - Required: o_mem_addr=0x200.
  - Stimulus: B=0x55.
  - Required: o_mem_wdata=0x55.
- LUI and shift:
  - Stimulus: IR=0x3C011234, MemtoReg=11.
  - Required: o_rf_wdata=0x12340000.
  - Stimulus: IR=0x00021140, ALUSrcA=10.
  - Required: o_alu_a=5.
